usb_in_ep_ctrl: RTL and testbench

//  Device-side IN-transaction sequencer between the token decoder and the SIE transmitter (TX_DP/TX_DM/TX_en path).
//  On each IN token it picks DATA0/DATA1, NAK or STALL for the addressed endpoint and starts the SIE transmitter.

---
 rtl/usb_pkg.sv | 19 +
 rtl/usb_turnaround_timer.sv | 29 ++
 rtl/usb_in_ep_ctrl.sv | 152 +++++++++++++++
 tb/tb_usb_in_ep_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB PID encodings and the IN-sequencer state type.
package usb_pkg;

    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_TX,
        WAIT_HS
    } state_e;

endpackage

// File: rtl/usb_turnaround_timer.sv
// Handshake turnaround down-counter: load to TIMEOUT_CYC-1, count while run, expired at zero.
// Latency: load/run act on the next edge; expired is decoded from the registered count.
// Backpressure: none; deasserting run freezes the count.
module usb_turnaround_timer #(
    parameter int  TIMEOUT_CYC = 72,
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(TIMEOUT_CYC - 1);
        end else if (run && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/usb_in_ep_ctrl.sv
// Device IN-transaction sequencer: picks DATA0/1, NAK or STALL per IN token and tracks toggles.
// Latency: token at cycle N -> tx_start_o at N+1; ack/rewind one cycle after handshake or expiry.
// Backpressure: none; tokens arriving while busy are dropped (tok_drop_o), the host retries.
module usb_in_ep_ctrl
    import usb_pkg::*;
#(
    parameter int  NUM_EP      = 4,
    parameter int  LEN_W       = 7,
    parameter int  TIMEOUT_CYC = 72,
    localparam int EP_W        = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic                    SIE_clk,
    input  logic                    Rst,
    input  logic                    tok_valid_i,
    input  logic [3:0]              tok_pid_i,
    input  logic [3:0]              tok_ep_i,
    input  logic [NUM_EP-1:0]       ep_ready_i,
    input  logic [NUM_EP-1:0]       ep_stall_i,
    input  logic [NUM_EP*LEN_W-1:0] ep_len_i,
    input  logic                    hs_valid_i,
    input  logic [3:0]              hs_pid_i,
    input  logic                    tx_done_i,
    output logic                    tx_start_o,
    output logic [3:0]              tx_pid_o,
    output logic [EP_W-1:0]         tx_ep_o,
    output logic [LEN_W-1:0]        tx_len_o,
    output logic [NUM_EP-1:0]       ep_ack_o,
    output logic [NUM_EP-1:0]       ep_rewind_o,
    output logic [NUM_EP-1:0]       toggle_o,
    output logic                    tok_drop_o,
    output logic                    busy_o
);

    state_e           state;
    logic             is_data;
    logic [EP_W-1:0]  tok_ep;
    logic [LEN_W-1:0] tok_len;
    logic             tok_in;
    logic             tok_setup;
    logic             tok_ep_ok;
    logic             setup_same_ep;
    logic             hs_ack;
    logic             timer_load;
    logic             timer_expired;

    assign tok_in        = tok_valid_i && (tok_pid_i == PID_IN);
    assign tok_setup     = tok_valid_i && (tok_pid_i == PID_SETUP);
    assign tok_ep_ok     = int'(tok_ep_i) < NUM_EP;
    assign tok_ep        = tok_ep_i[EP_W-1:0];
    assign setup_same_ep = tok_setup && tok_ep_ok && (tok_ep == tx_ep_o);
    assign hs_ack        = hs_valid_i && (hs_pid_i == PID_ACK);
    assign timer_load    = (state == WAIT_TX) && tx_done_i && is_data;
    assign busy_o        = (state != IDLE);

    always_comb begin
        tok_len = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (tok_ep == EP_W'(i)) begin
                tok_len = ep_len_i[i*LEN_W +: LEN_W];
            end
        end
    end

    usb_turnaround_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (SIE_clk),
        .rst     (Rst),
        .load    (timer_load),
        .run     (state == WAIT_HS),
        .expired (timer_expired)
    );

    always_ff @(posedge SIE_clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            is_data     <= 1'b0;
            tx_start_o  <= 1'b0;
            tx_pid_o    <= '0;
            tx_ep_o     <= '0;
            tx_len_o    <= '0;
            ep_ack_o    <= '0;
            ep_rewind_o <= '0;
            toggle_o    <= '0;
            tok_drop_o  <= 1'b0;
        end else begin
            tx_start_o  <= 1'b0;
            ep_ack_o    <= '0;
            ep_rewind_o <= '0;
            tok_drop_o  <= 1'b0;

            case (state)
                IDLE: begin
                    if (tok_in && tok_ep_ok) begin
                        tx_ep_o    <= tok_ep;
                        tx_start_o <= 1'b1;
                        state      <= START;
                        if (ep_stall_i[tok_ep]) begin
                            tx_pid_o <= PID_STALL;
                            tx_len_o <= '0;
                            is_data  <= 1'b0;
                        end else if (ep_ready_i[tok_ep]) begin
                            tx_pid_o <= toggle_o[tok_ep] ? PID_DATA1 : PID_DATA0;
                            tx_len_o <= tok_len;
                            is_data  <= 1'b1;
                        end else begin
                            tx_pid_o <= PID_NAK;
                            tx_len_o <= '0;
                            is_data  <= 1'b0;
                        end
                    end
                end
                START: begin
                    tok_drop_o <= tok_in;
                    state      <= WAIT_TX;
                end
                WAIT_TX: begin
                    tok_drop_o <= tok_in;
                    if (tx_done_i) begin
                        state <= is_data ? WAIT_HS : IDLE;
                    end
                end
                WAIT_HS: begin
                    // A new token means the host gave up on this handshake.
                    if (tok_in || setup_same_ep) begin
                        ep_rewind_o[tx_ep_o] <= 1'b1;
                        tok_drop_o           <= tok_in;
                        state                <= IDLE;
                    end else if (hs_valid_i) begin
                        if (hs_ack) begin
                            ep_ack_o[tx_ep_o] <= 1'b1;
                            toggle_o[tx_ep_o] <= ~toggle_o[tx_ep_o];
                        end else begin
                            ep_rewind_o[tx_ep_o] <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (timer_expired) begin
                        ep_rewind_o[tx_ep_o] <= 1'b1;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed last so a SETUP overrides an ACK flip on the same endpoint.
            if (tok_setup && tok_ep_ok) begin
                toggle_o[tok_ep] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_in_ep_ctrl.sv
// Directed + randomized bench for usb_in_ep_ctrl against a transaction-level reference model.
module tb_usb_in_ep_ctrl;
    import usb_pkg::*;

    localparam int NUM_EP = 4;
    localparam int LEN_W  = 7;
    localparam int EP_W   = 2;

    logic                    SIE_clk = 1'b0;
    logic                    Rst     = 1'b1;
    logic                    tok_valid_i = 1'b0;
    logic [3:0]              tok_pid_i   = '0;
    logic [3:0]              tok_ep_i    = '0;
    logic [NUM_EP-1:0]       ep_ready_i  = '0;
    logic [NUM_EP-1:0]       ep_stall_i  = '0;
    logic [NUM_EP*LEN_W-1:0] ep_len_i    = '0;
    logic                    hs_valid_i  = 1'b0;
    logic [3:0]              hs_pid_i    = '0;
    logic                    tx_done_i   = 1'b0;
    logic                    tx_start_o;
    logic [3:0]              tx_pid_o;
    logic [EP_W-1:0]         tx_ep_o;
    logic [LEN_W-1:0]        tx_len_o;
    logic [NUM_EP-1:0]       ep_ack_o;
    logic [NUM_EP-1:0]       ep_rewind_o;
    logic [NUM_EP-1:0]       toggle_o;
    logic                    tok_drop_o;
    logic                    busy_o;

    always #5 SIE_clk = ~SIE_clk;

    usb_in_ep_ctrl #(.NUM_EP(NUM_EP), .LEN_W(LEN_W), .TIMEOUT_CYC(72)) dut (
        .SIE_clk     (SIE_clk),
        .Rst         (Rst),
        .tok_valid_i (tok_valid_i),
        .tok_pid_i   (tok_pid_i),
        .tok_ep_i    (tok_ep_i),
        .ep_ready_i  (ep_ready_i),
        .ep_stall_i  (ep_stall_i),
        .ep_len_i    (ep_len_i),
        .hs_valid_i  (hs_valid_i),
        .hs_pid_i    (hs_pid_i),
        .tx_done_i   (tx_done_i),
        .tx_start_o  (tx_start_o),
        .tx_pid_o    (tx_pid_o),
        .tx_ep_o     (tx_ep_o),
        .tx_len_o    (tx_len_o),
        .ep_ack_o    (ep_ack_o),
        .ep_rewind_o (ep_rewind_o),
        .toggle_o    (toggle_o),
        .tok_drop_o  (tok_drop_o),
        .busy_o      (busy_o)
    );

    int tests = 0;
    int fails = 0;
    logic [NUM_EP-1:0] m_tog;   // reference data toggles

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge SIE_clk);
        #1;
    endtask

    task automatic send_tok(input logic [3:0] pid, input logic [3:0] ep);
        tok_valid_i = 1'b1;
        tok_pid_i   = pid;
        tok_ep_i    = ep;
        tick();
        tok_valid_i = 1'b0;
        tok_pid_i   = '0;
        tok_ep_i    = '0;
    endtask

    task automatic pulse_hs(input logic [3:0] pid);
        hs_valid_i = 1'b1;
        hs_pid_i   = pid;
        tick();
        hs_valid_i = 1'b0;
        hs_pid_i   = '0;
    endtask

    // mode: 0 ACK after d cycles, 1 non-ACK after d, 2 timeout, 4 IN during WAIT_HS,
    //       5 SETUP same ep during WAIT_HS, 6 reset during WAIT_HS
    task automatic run_in(input int ep, input int mode, input int d, input bit drop_in_tx);
        logic [3:0]       e_pid;
        logic [LEN_W-1:0] e_len;
        logic [3:0]       bad_pid;
        bit               e_data;
        logic [31:0]      one_hot;
        if (ep >= NUM_EP) begin
            send_tok(PID_IN, 4'(ep));
            chk("oor_start", 32'(tx_start_o), 0);
            chk("oor_busy", 32'(busy_o), 0);
            tick();
            chk("oor_start_late", 32'(tx_start_o), 0);
            return;
        end
        one_hot = 32'(1) << ep;
        e_data  = 1'b0;
        e_len   = '0;
        if (ep_stall_i[ep]) begin
            e_pid = PID_STALL;
        end else if (ep_ready_i[ep]) begin
            e_data = 1'b1;
            e_pid  = m_tog[ep] ? PID_DATA1 : PID_DATA0;
            e_len  = ep_len_i[ep*LEN_W +: LEN_W];
        end else begin
            e_pid = PID_NAK;
        end

        send_tok(PID_IN, 4'(ep));
        chk("start", 32'(tx_start_o), 1);
        chk("pid", 32'(tx_pid_o), 32'(e_pid));
        chk("len", 32'(tx_len_o), 32'(e_len));
        chk("ep", 32'(tx_ep_o), 32'(ep));
        chk("busy_start", 32'(busy_o), 1);
        ep_ready_i = 4'($urandom);
        ep_len_i   = 28'($urandom);

        if (drop_in_tx) begin
            send_tok(PID_IN, 4'(ep));
            chk("drop_in_tx", 32'(tok_drop_o), 1);
            chk("start_one_shot", 32'(tx_start_o), 0);
            tick();
            chk("no_restart", 32'(tx_start_o), 0);
            chk("drop_one_shot", 32'(tok_drop_o), 0);
        end else begin
            tick();
            chk("start_one_shot", 32'(tx_start_o), 0);
        end
        repeat ($urandom_range(0, 3)) tick();
        chk("pid_held", 32'(tx_pid_o), 32'(e_pid));
        chk("len_held", 32'(tx_len_o), 32'(e_len));
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        chk("busy_after_tx", 32'(busy_o), 32'(e_data));

        if (e_data) begin
            case (mode)
                0: begin
                    repeat (d - 1) tick();
                    pulse_hs(PID_ACK);
                    chk("ack", 32'(ep_ack_o), one_hot);
                    chk("ack_no_rewind", 32'(ep_rewind_o), 0);
                    m_tog[ep] = ~m_tog[ep];
                end
                1: begin
                    do bad_pid = 4'($urandom); while (bad_pid == PID_ACK);
                    repeat (d - 1) tick();
                    pulse_hs(bad_pid);
                    chk("nak_rewind", 32'(ep_rewind_o), one_hot);
                    chk("nak_no_ack", 32'(ep_ack_o), 0);
                end
                2: begin
                    repeat (71) tick();
                    chk("pre_expiry_rewind", 32'(ep_rewind_o), 0);
                    chk("pre_expiry_busy", 32'(busy_o), 1);
                    tick();
                    chk("expiry_rewind", 32'(ep_rewind_o), one_hot);
                    chk("expiry_no_ack", 32'(ep_ack_o), 0);
                end
                4: begin
                    repeat (d - 1) tick();
                    send_tok(PID_IN, 4'(ep));
                    chk("in_hs_rewind", 32'(ep_rewind_o), one_hot);
                    chk("in_hs_drop", 32'(tok_drop_o), 1);
                end
                5: begin
                    repeat (d - 1) tick();
                    send_tok(PID_SETUP, 4'(ep));
                    chk("setup_hs_rewind", 32'(ep_rewind_o), one_hot);
                    chk("setup_hs_nodrop", 32'(tok_drop_o), 0);
                    m_tog[ep] = 1'b1;
                end
                default: begin
                    repeat (d - 1) tick();
                    #2 Rst = 1'b1;
                    #1;
                    m_tog = '0;
                    chk("rst_toggle", 32'(toggle_o), 0);
                    chk("rst_outputs", 32'({tx_start_o, tx_pid_o, tx_ep_o, tx_len_o, ep_ack_o,
                                            ep_rewind_o, tok_drop_o, busy_o}), 0);
                    tick();
                    #2 Rst = 1'b0;
                    tick();
                    chk("rst_no_pulse", 32'({ep_ack_o, ep_rewind_o}), 0);
                end
            endcase
        end
        chk("idle_after", 32'(busy_o), 0);
        tick();
        chk("pulses_clear", 32'({ep_ack_o, ep_rewind_o, tok_drop_o}), 0);
        chk("toggles", 32'(toggle_o), 32'(m_tog));
    endtask

    initial begin
        int e;
        int r;
        int mode;
        m_tog = '0;
        repeat (2) tick();
        chk("reset_toggle", 32'(toggle_o), 0);
        chk("reset_outputs", 32'({tx_start_o, tx_pid_o, tx_ep_o, tx_len_o, ep_ack_o,
                                  ep_rewind_o, tok_drop_o, busy_o}), 0);
        @(negedge SIE_clk);
        Rst = 1'b0;
        tick();

        // ep1 DATA0 len 8, ACK 10 cycles after tx_done
        ep_ready_i = 4'b0010;
        ep_len_i   = '0;
        ep_len_i[1*LEN_W +: LEN_W] = 7'd8;
        run_in(1, 0, 10, 1'b0);
        chk("t1_toggle1", 32'(toggle_o[1]), 1);

        // ep1 timeout then resend as DATA1
        ep_ready_i = 4'b0010;
        ep_len_i[1*LEN_W +: LEN_W] = 7'd8;
        run_in(1, 2, 0, 1'b0);
        ep_ready_i = 4'b0010;
        ep_len_i[1*LEN_W +: LEN_W] = 7'd8;
        run_in(1, 1, $urandom_range(1, 72), 1'b0);
        chk("t2_toggle_kept", 32'(toggle_o[1]), 1);

        // NAK, STALL, out-of-range endpoint
        ep_ready_i = '0;
        run_in(2, 0, 1, 1'b0);
        ep_stall_i = 4'b0100;
        ep_ready_i = 4'b0100;
        run_in(2, 0, 1, 1'b0);
        ep_stall_i = '0;
        run_in(7, 0, 1, 1'b0);

        // SETUP forces DATA1; ZLP ACKed exactly on expiry
        send_tok(PID_SETUP, 4'd0);
        m_tog[0] = 1'b1;
        chk("setup_toggle", 32'(toggle_o), 32'(m_tog));
        chk("setup_no_start", 32'(tx_start_o), 0);
        ep_ready_i = 4'b0001;
        ep_len_i   = '0;
        run_in(0, 0, 72, 1'b0);

        // drops while busy, SETUP abort
        ep_ready_i = 4'b1000;
        run_in(3, 4, $urandom_range(1, 72), 1'b1);
        ep_ready_i = 4'b0100;
        run_in(2, 5, $urandom_range(1, 72), 1'b0);

        // async reset in WAIT_HS, then DATA0 again
        ep_ready_i = 4'b0010;
        run_in(1, 6, 5, 1'b0);
        ep_ready_i = 4'b0010;
        run_in(1, 0, $urandom_range(1, 72), 1'b0);

        for (int k = 0; k < 25; k++) begin
            ep_ready_i = 4'($urandom);
            ep_stall_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            ep_len_i   = 28'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                e = int'($urandom_range(0, NUM_EP - 1));
                send_tok(PID_SETUP, 4'(e));
                m_tog[e] = 1'b1;
            end
            r = int'($urandom_range(0, 9));
            mode = (r < 5) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : (r == 8) ? 4 : 5;
            run_in(int'($urandom_range(0, 5)), mode, int'($urandom_range(1, 72)),
                   1'($urandom_range(0, 1)));
        end
        chk("final_toggles", 32'(toggle_o), 32'(m_tog));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
